// File: rtl/mure_pkg.sv
// Shared trace-encoder types: scheduler state, commit entry payload, default widths.
package mure_pkg;

    localparam int unsigned TE_DROP_CNT_LEN = 16;
    localparam int unsigned TE_IADDR_LEN    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } te_sched_state_e;

    // One committed instruction as seen by the trace fsm
    typedef struct packed {
        logic [2:0]              itype;
        logic [TE_IADDR_LEN-1:0] iaddr;
        logic [1:0]              priv;
        logic                    compressed;
    } fifo_entry_s;

endpackage

// File: rtl/te_commit_scheduler.sv
// Commit scheduler: compacts up to NR_PORTS commit entries per cycle into an
// in-order circular buffer and issues them one per cycle to the trace fsm.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   enable_i, flush_i        trace enable, synchronous buffer discard
//   valid_i, entry_i         per-port commit entries (port 0 oldest)
//   entry_valid_o/ready_i    head handshake towards the fsm; entry_o is the head
//   idle_o                   idle with empty buffer
//   overflow_o, drop_cnt_o   sticky drop flag and saturating drop count
//   clr_overflow_i           clears the drop accounting
module te_commit_scheduler
    import mure_pkg::*;
#(
    parameter int unsigned NR_PORTS     = 2,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned DROP_CNT_LEN = TE_DROP_CNT_LEN
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        enable_i,
    input  logic                        flush_i,
    input  logic [NR_PORTS-1:0]         valid_i,
    input  fifo_entry_s [NR_PORTS-1:0]  entry_i,
    output logic                        entry_valid_o,
    input  logic                        entry_ready_i,
    output fifo_entry_s                 entry_o,
    output logic                        idle_o,
    output logic                        overflow_o,
    input  logic                        clr_overflow_i,
    output logic [DROP_CNT_LEN-1:0]     drop_cnt_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned PCNT_W = $clog2(NR_PORTS + 1);
    localparam int unsigned SUM_W  = ((CNT_W > PCNT_W) ? CNT_W : PCNT_W) + 1;
    localparam int unsigned DEXT_W = DROP_CNT_LEN + 1;

    te_sched_state_e state_q, state_d;

    fifo_entry_s             buf_q [DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_after_pop;
    logic                    overflow_q;
    logic [DROP_CNT_LEN-1:0] drop_cnt_q;

    logic                    push_en, pop;
    logic [SUM_W-1:0]        offs [NR_PORTS];
    logic [SUM_W-1:0]        n_valid, free, n_push, n_drop;
    logic [DEXT_W-1:0]       drop_base, drop_sum;

    // Head view is derived from registers only
    assign entry_valid_o = (count_q != '0) && (state_q != IDLE);
    assign entry_o       = (count_q != '0) ? buf_q[rd_ptr_q] : '0;
    assign idle_o        = (state_q == IDLE) && (count_q == '0);
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;

    // Flush discards both the push and the pop of its cycle
    assign pop     = entry_valid_o && entry_ready_i && !flush_i;
    assign push_en = (state_q == RUN) && enable_i && !flush_i;

    // Compaction offsets and free-space clipping; free uses the registered count
    always_comb begin
        n_valid = '0;
        for (int i = 0; i < int'(NR_PORTS); i++) begin
            offs[i] = n_valid;
            if (push_en && valid_i[i]) begin
                n_valid = n_valid + SUM_W'(1);
            end
        end
        free            = SUM_W'(DEPTH) - SUM_W'(count_q);
        n_push          = (n_valid > free) ? free : n_valid;
        n_drop          = n_valid - n_push;
        count_after_pop = count_q - CNT_W'(pop);
        drop_base       = clr_overflow_i ? '0 : {1'b0, drop_cnt_q};
        drop_sum        = drop_base + DEXT_W'(n_drop);
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (enable_i) state_d = RUN;
            RUN:   if (!enable_i) state_d = DRAIN;
            DRAIN: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (enable_i) begin
                    state_d = RUN;
                end else if (count_after_pop == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer storage, pointers and count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < int'(NR_PORTS); i++) begin
                if (push_en && valid_i[i] && (offs[i] < free)) begin
                    buf_q[wr_ptr_q + PTR_W'(offs[i])] <= entry_i[i];
                end
            end
            wr_ptr_q <= wr_ptr_q + PTR_W'(n_push);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(n_push) - CNT_W'(pop);
        end
    end

    // Drop accounting; a same-cycle drop overrides the clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (n_drop != '0) begin
            overflow_q <= 1'b1;
            drop_cnt_q <= drop_sum[DROP_CNT_LEN] ? '1 : drop_sum[DROP_CNT_LEN-1:0];
        end else if (clr_overflow_i) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_te_commit_scheduler.sv
module tb_te_commit_scheduler;
    import mure_pkg::*;

    localparam int NP  = 2;
    localparam int DP  = 8;
    localparam int DCL = 16;
    localparam int DMAX = (1 << DCL) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              flush = 1'b0;
    logic              ready = 1'b0;
    logic              clr = 1'b0;
    logic [NP-1:0]     valid = '0;
    fifo_entry_s [NP-1:0] ent;
    logic              entry_valid;
    fifo_entry_s       entry;
    logic              idle;
    logic              ovf;
    logic [DCL-1:0]    dcnt;

    // Reference model: queue of entries plus a mode (0 off, 1 tracing, 2 draining)
    fifo_entry_s mq[$];
    int          m_mode;
    bit          m_ovf;
    int          m_dcnt;

    int n_checks = 0;
    int n_pass   = 0;

    te_commit_scheduler #(.NR_PORTS(NP), .DEPTH(DP), .DROP_CNT_LEN(DCL)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (en),
        .flush_i        (flush),
        .valid_i        (valid),
        .entry_i        (ent),
        .entry_valid_o  (entry_valid),
        .entry_ready_i  (ready),
        .entry_o        (entry),
        .idle_o         (idle),
        .overflow_o     (ovf),
        .clr_overflow_i (clr),
        .drop_cnt_o     (dcnt)
    );

    always #5 clk = ~clk;

    function automatic fifo_entry_s rand_entry();
        fifo_entry_s e;
        e.itype      = 3'($urandom);
        e.iaddr      = 32'($urandom);
        e.priv       = 2'($urandom);
        e.compressed = 1'($urandom);
        return e;
    endfunction

    function automatic bit exp_valid();
        return (mq.size() != 0) && (m_mode != 0);
    endfunction

    function automatic fifo_entry_s exp_entry();
        fifo_entry_s e;
        e = '0;
        if (mq.size() != 0) e = mq[0];
        return e;
    endfunction

    function automatic bit exp_idle();
        return (m_mode == 0) && (mq.size() == 0);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_mode = 0;
        m_ovf  = 1'b0;
        m_dcnt = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_update();
        int  free;
        int  nacc;
        int  ndrop;
        bit  popped;
        popped = exp_valid() && ready && !flush;
        free   = DP - mq.size();
        nacc   = 0;
        ndrop  = 0;
        if (popped) void'(mq.pop_front());
        if (m_mode == 1 && en && !flush) begin
            for (int p = 0; p < NP; p++) begin
                if (valid[p]) begin
                    if (nacc < free) begin
                        mq.push_back(ent[p]);
                        nacc++;
                    end else begin
                        ndrop++;
                    end
                end
            end
        end
        if (flush) mq.delete();
        if (ndrop > 0) begin
            m_dcnt = (clr ? 0 : m_dcnt) + ndrop;
            if (m_dcnt > DMAX) m_dcnt = DMAX;
            m_ovf = 1'b1;
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_dcnt = 0;
        end
        case (m_mode)
            0: if (en) m_mode = 1;
            1: if (!en) m_mode = 2;
            default: begin
                if (flush) m_mode = 0;
                else if (en) m_mode = 1;
                else if (mq.size() == 0) m_mode = 0;
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        n_checks++; if (entry_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", entry_valid); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL reset_idle: got %0b expected 1", idle); else n_pass++;
        n_checks++; if (entry !== '0) $display("FAIL reset_entry: got %h expected 0", entry); else n_pass++;
        n_checks++; if (ovf !== 1'b0 || dcnt !== '0) $display("FAIL reset_drop: got ovf=%0b cnt=%0d expected 0/0", ovf, dcnt); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        en = 1'b1;
        step();
        valid = 2'b01;
        ent[0] = rand_entry();
        ent[0].iaddr = 32'h8000_0000;
        ready = 1'b1;
        step();
        valid = '0;
        n_checks++; if (entry_valid !== 1'b1) $display("FAIL single_valid: got %0b expected 1", entry_valid); else n_pass++;
        n_checks++; if (entry.iaddr !== 32'h8000_0000) $display("FAIL single_iaddr: got %h expected 80000000", entry.iaddr); else n_pass++;
        n_checks++; if (idle !== 1'b0) $display("FAIL single_idle: got %0b expected 0", idle); else n_pass++;
        step();
        n_checks++; if (entry_valid !== 1'b0) $display("FAIL single_popped: got %0b expected 0", entry_valid); else n_pass++;
    endtask

    task automatic test_hold();
        fifo_entry_s a;
        fifo_entry_s b;
        a = rand_entry();
        b = rand_entry();
        ready = 1'b0;
        valid = 2'b11;
        ent[0] = a;
        ent[1] = b;
        step();
        valid = '0;
        ent[0] = rand_entry();
        ent[1] = rand_entry();
        for (int c = 0; c < 2; c++) begin
            n_checks++; if (entry !== a || entry_valid !== 1'b1) $display("FAIL hold_a%0d: got %h/%0b expected %h/1", c, entry, entry_valid, a); else n_pass++;
            step();
        end
        ready = 1'b1;
        n_checks++; if (entry !== a) $display("FAIL hold_a_ready: got %h expected %h", entry, a); else n_pass++;
        step();
        n_checks++; if (entry !== b || entry !== exp_entry()) $display("FAIL hold_b: got %h expected %h", entry, b); else n_pass++;
        step();
        n_checks++; if (entry_valid !== 1'b0 || entry !== '0) $display("FAIL hold_empty: got %0b/%h expected 0/0", entry_valid, entry); else n_pass++;
    endtask

    task automatic test_overflow();
        ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            valid = 2'b11;
            ent[0] = rand_entry();
            ent[1] = rand_entry();
            step();
        end
        valid = '0;
        n_checks++; if (dcnt !== 16'd2 || dcnt !== 16'(m_dcnt)) $display("FAIL ovf_cnt: got %0d expected 2", dcnt); else n_pass++;
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_flag: got %0b expected 1", ovf); else n_pass++;
        n_checks++; if (mq.size() != 8 || entry !== exp_entry()) $display("FAIL ovf_head: got %h expected %h (model depth %0d)", entry, exp_entry(), mq.size()); else n_pass++;
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_checks++; if (ovf !== 1'b0 || dcnt !== '0) $display("FAIL ovf_clear: got ovf=%0b cnt=%0d expected 0/0", ovf, dcnt); else n_pass++;
        ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            n_checks++; if (entry_valid !== exp_valid() || entry !== exp_entry()) $display("FAIL ovf_drain%0d: got %0b/%h expected %0b/%h", c, entry_valid, entry, exp_valid(), exp_entry()); else n_pass++;
            step();
        end
        n_checks++; if (entry_valid !== 1'b0) $display("FAIL ovf_empty: got %0b expected 0", entry_valid); else n_pass++;
    endtask

    task automatic test_drain();
        ready = 1'b0;
        valid = 2'b11;
        ent[0] = rand_entry();
        ent[1] = rand_entry();
        step();
        valid = 2'b01;
        ent[0] = rand_entry();
        step();
        en = 1'b0;
        valid = 2'b11;
        ent[0] = rand_entry();
        ent[1] = rand_entry();
        step();
        ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ent[0] = rand_entry();
            ent[1] = rand_entry();
            n_checks++; if (entry_valid !== 1'b1 || entry !== exp_entry()) $display("FAIL drain_pop%0d: got %0b/%h expected 1/%h", c, entry_valid, entry, exp_entry()); else n_pass++;
            n_checks++; if (idle !== 1'b0) $display("FAIL drain_busy%0d: got %0b expected 0", c, idle); else n_pass++;
            step();
        end
        valid = '0;
        n_checks++; if (idle !== 1'b1 || idle !== exp_idle()) $display("FAIL drain_idle: got %0b expected 1", idle); else n_pass++;
        n_checks++; if (entry_valid !== 1'b0) $display("FAIL drain_empty: got %0b expected 0", entry_valid); else n_pass++;
    endtask

    task automatic test_flush();
        en = 1'b1;
        ready = 1'b0;
        step();
        for (int c = 0; c < 2; c++) begin
            valid = 2'b11;
            ent[0] = rand_entry();
            ent[1] = rand_entry();
            step();
        end
        n_checks++; if (entry_valid !== 1'b1 || mq.size() != 4) $display("FAIL flush_pre: got %0b expected 1 (model depth %0d)", entry_valid, mq.size()); else n_pass++;
        flush = 1'b1;
        ready = 1'b1;
        ent[0] = rand_entry();
        ent[1] = rand_entry();
        step();
        flush = 1'b0;
        valid = '0;
        ready = 1'b0;
        n_checks++; if (entry_valid !== 1'b0 || entry !== '0) $display("FAIL flush_empty: got %0b/%h expected 0/0", entry_valid, entry); else n_pass++;
        n_checks++; if (idle !== exp_idle()) $display("FAIL flush_idle: got %0b expected %0b", idle, exp_idle()); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        fifo_entry_s e;
        ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            valid = (c == 2) ? 2'b01 : 2'b11;
            ent[0] = rand_entry();
            ent[1] = rand_entry();
            step();
        end
        valid = '0;
        n_checks++; if (mq.size() != 5 || entry !== exp_entry()) $display("FAIL rst_pre: got %h expected %h", entry, exp_entry()); else n_pass++;
        #2;
        rst_n = 1'b0;
        en = 1'b0;
        model_reset();
        #1;
        n_checks++; if (entry_valid !== 1'b0 || idle !== 1'b1) $display("FAIL rst_mid: got valid=%0b idle=%0b expected 0/1", entry_valid, idle); else n_pass++;
        n_checks++; if (entry !== '0) $display("FAIL rst_mid_entry: got %h expected 0", entry); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        step();
        e = rand_entry();
        valid = 2'b10;
        ent[0] = rand_entry();
        ent[1] = e;
        step();
        valid = '0;
        n_checks++; if (entry !== e || entry_valid !== 1'b1) $display("FAIL rst_restart: got %h/%0b expected %h/1", entry, entry_valid, e); else n_pass++;
        ready = 1'b1;
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            en    = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            clr   = ($urandom_range(0, 19) == 0);
            ready = ($urandom_range(0, 2) == 0);
            valid = 2'($urandom);
            ent[0] = rand_entry();
            ent[1] = rand_entry();
            n_checks++; if (entry_valid !== exp_valid()) $display("FAIL rnd_valid@%0d: got %0b expected %0b", c, entry_valid, exp_valid()); else n_pass++;
            n_checks++; if (entry !== exp_entry()) $display("FAIL rnd_entry@%0d: got %h expected %h", c, entry, exp_entry()); else n_pass++;
            n_checks++; if (idle !== exp_idle()) $display("FAIL rnd_idle@%0d: got %0b expected %0b", c, idle, exp_idle()); else n_pass++;
            n_checks++; if (ovf !== m_ovf || dcnt !== 16'(m_dcnt)) $display("FAIL rnd_drop@%0d: got %0b/%0d expected %0b/%0d", c, ovf, dcnt, m_ovf, m_dcnt); else n_pass++;
            step();
        end
        en = 1'b0; flush = 1'b0; clr = 1'b0; valid = '0;
    endtask

    initial begin
        ent = '0;
        test_reset();
        test_single();
        test_hold();
        test_overflow();
        test_drain();
        test_flush();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
